// File: rtl/ym3016_serial_tx.sv
// ---------------------------------------------------------------------------
// ym3016_serial_tx
//
// Serialises stereo 16-bit PCM pairs into the YM3016 floating-point serial
// format. Each 32-bit frame holds a left word (bits 0-15) followed by a
// right word (bits 16-31). Each word is sent as 3 zero bits, a 10-bit
// mantissa (LSB first), then a 3-bit exponent (LSB first). The bit clock
// dac_clk is divided down from clk. Data and strobes change only on the
// clk cycle where dac_clk rises, so they are stable at each falling edge.
//
// A one-deep holding register decouples the sample source from the frame
// timing. If no fresh pair is waiting when a frame starts, the last pair is
// sent again and underrun pulses for one clk cycle.
//
// Parameters
//   HALF_PERIOD  clk cycles per dac_clk half-period (2..255)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sample_l      left sample, signed two's complement
//   sample_r      right sample, signed two's complement
//   sample_valid  sample pair offered
//   sample_ready  holding register empty (pair will be taken)
//   dac_clk       serial bit clock
//   dac_so        serial data
//   dac_sh1       left-word latch strobe (high during bit 15)
//   dac_sh2       right-word latch strobe (high during bit 31)
//   underrun      one-cycle pulse when a frame repeats the previous pair
// ---------------------------------------------------------------------------
module ym3016_serial_tx #(
  parameter int HALF_PERIOD = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_clk,
  output logic        dac_so,
  output logic        dac_sh1,
  output logic        dac_sh2,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [4:0] BIT_LEFT_LAST  = 5'd15;
  localparam logic [4:0] BIT_RIGHT_LAST = 5'd31;

  // -------------------------------------------------------------------------
  // Float encoder: pick the smallest exponent (1..7) whose shifted value fits
  // in a signed 10-bit mantissa. The arithmetic shift truncates toward -inf.
  // A 16-bit input shifted by 6 always fits, so exponent 7 is the fallback.
  // -------------------------------------------------------------------------
  function automatic logic [15:0] encode_word(input logic signed [15:0] s);
    logic signed [15:0] shifted;
    logic [9:0]         mant;
    logic [2:0]         expo;
    logic               found;
    mant  = 10'(s >>> 6);
    expo  = 3'd7;
    found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      shifted = s >>> k;
      if (!found && (shifted >= -16'sd512) && (shifted <= 16'sd511)) begin
        mant  = shifted[9:0];
        expo  = 3'(k + 1);
        found = 1'b1;
      end
    end
    // Word is sent LSB first: 3 zero bits, mantissa, exponent.
    return {expo, mant, 3'b000};
  endfunction

  // -------------------------------------------------------------------------
  // Bit-clock divider
  // -------------------------------------------------------------------------
  logic [7:0] div_cnt;
  logic       div_wrap;
  logic       bit_rise;

  assign div_wrap = (div_cnt == DIV_LAST);
  // The cycle in which dac_clk goes 0->1 is the only cycle that advances the
  // serial state.
  assign bit_rise = div_wrap && !dac_clk;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 8'd0;
      dac_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= 8'd0;
      dac_clk <= !dac_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Frame position. Reset parks the index at 31 so the first rise after
  // reset carries bit 0 of a fresh frame.
  // -------------------------------------------------------------------------
  logic [4:0] bit_idx;
  logic [4:0] next_idx;
  logic       frame_load;

  assign next_idx   = bit_idx + 5'd1;
  assign frame_load = bit_rise && (bit_idx == BIT_RIGHT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= BIT_RIGHT_LAST;
    end else if (bit_rise) begin
      bit_idx <= next_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Holding register and last-sent pair
  // -------------------------------------------------------------------------
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic        hold_full;
  logic [15:0] last_l;
  logic [15:0] last_r;

  assign sample_ready = !hold_full;

  // Load and capture never collide: capture needs hold_full low, load only
  // consumes the register when hold_full is high. When the register is empty
  // in the load cycle, the frame repeats the last pair and the offered pair
  // is captured for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_l    <= 16'd0;
      hold_r    <= 16'd0;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_l    <= sample_l;
      hold_r    <= sample_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_l <= 16'd0;
      last_r <= 16'd0;
    end else if (frame_load && hold_full) begin
      last_l <= hold_l;
      last_r <= hold_r;
    end
  end

  // -------------------------------------------------------------------------
  // Frame encoding: choose the fresh pair if one is waiting, else repeat.
  // -------------------------------------------------------------------------
  logic [15:0] src_l;
  logic [15:0] src_r;
  logic [31:0] new_frame;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src_l     = last_l;
    src_r     = last_r;
    if (hold_full) begin
      src_l = hold_l;
      src_r = hold_r;
    end
    new_frame = {encode_word($signed(src_r)), encode_word($signed(src_l))};
  end

  // -------------------------------------------------------------------------
  // Serial shifter and strobes. Bit 0 goes straight to dac_so in the load
  // cycle; the remaining 31 bits wait in the shift register.
  // -------------------------------------------------------------------------
  logic [30:0] shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= 31'd0;
      dac_so    <= 1'b0;
      dac_sh1   <= 1'b0;
      dac_sh2   <= 1'b0;
    end else if (bit_rise) begin
      if (frame_load) begin
        dac_so    <= new_frame[0];
        shift_reg <= new_frame[31:1];
      end else begin
        dac_so    <= shift_reg[0];
        shift_reg <= {1'b0, shift_reg[30:1]};
      end
      dac_sh1 <= (next_idx == BIT_LEFT_LAST);
      dac_sh2 <= (next_idx == BIT_RIGHT_LAST);
    end
  end

  // Registered so the pulse lines up with the bit-0 data it refers to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_load && !hold_full;
    end
  end

endmodule

// File: tb/tb_ym3016_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_ym3016_serial_tx
//
// Directed bench for ym3016_serial_tx. Outputs are sampled on the falling
// edge of clk. Every frame is captured bit by bit on dac_clk rises and
// compared with hand-computed mantissa/exponent words. A per-cycle monitor
// also tracks dac_clk period, output stability between rises, underrun
// pulses and handshake activity.
// ---------------------------------------------------------------------------
module tb_ym3016_serial_tx;

  localparam int HP = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_l = 16'd0;
  logic [15:0] sample_r = 16'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        dac_clk;
  logic        dac_so;
  logic        dac_sh1;
  logic        dac_sh2;
  logic        underrun;

  ym3016_serial_tx #(.HALF_PERIOD(HP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_clk      (dac_clk),
    .dac_so       (dac_so),
    .dac_sh1      (dac_sh1),
    .dac_sh2      (dac_sh2),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state
  logic prev_clk = 1'b0;
  logic prev_so  = 1'b0;
  logic prev_sh1 = 1'b0;
  logic prev_sh2 = 1'b0;
  logic prev_ur  = 1'b0;
  logic prev_rst = 1'b0;
  bit   first_rise = 1'b1;
  int   cyc      = 0;
  int   ur_cnt   = 0;
  int   ur_wide  = 0;
  int   acc_cnt  = 0;
  int   rdy_cnt  = 0;
  int   stab_err = 0;
  int   per_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] word(input logic [9:0] m, input logic [2:0] e);
    return {e, m, 3'b000};
  endfunction

  // One clk cycle of observation at the falling edge.
  task automatic tick(output logic rose);
    @(negedge clk);
    rose = reset_n && dac_clk && !prev_clk;
    cyc++;
    if (reset_n && prev_rst && !rose &&
        (dac_so !== prev_so || dac_sh1 !== prev_sh1 || dac_sh2 !== prev_sh2))
      stab_err++;
    if (underrun) begin
      ur_cnt++;
      if (prev_ur) ur_wide++;
    end
    if (sample_valid && sample_ready) acc_cnt++;
    if (sample_ready) rdy_cnt++;
    if (rose) begin
      if (cyc != (first_rise ? HP : 2 * HP)) per_err++;
      cyc        = 0;
      first_rise = 1'b0;
    end
    prev_clk = dac_clk;
    prev_so  = dac_so;
    prev_sh1 = dac_sh1;
    prev_sh2 = dac_sh2;
    prev_ur  = underrun;
    prev_rst = reset_n;
  endtask

  task automatic next_bit(output logic b, output logic s1, output logic s2);
    logic r;
    int   n;
    r = 1'b0;
    n = 0;
    while (!r && n < 4 * HP + 4) begin
      tick(r);
      n++;
    end
    if (!r) check("bit_timeout", 32'(r), 32'd1);
    b  = dac_so;
    s1 = dac_sh1;
    s2 = dac_sh2;
  endtask

  task automatic release_reset();
    logic r;
    tick(r);
    reset_n    = 1'b1;
    cyc        = 0;
    first_rise = 1'b1;
  endtask

  // Offer a pair and wait until it is taken.
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    logic rr;
    int   n;
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 400) begin
      tick(rr);
      n++;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    check($sformatf("accept_%h_%h", l, r), 32'(sample_ready), 32'd0);
  endtask

  // Capture one full frame (next rise is assumed to carry bit 0) and compare.
  task automatic check_frame(input string tag,
                             input logic [9:0] ml, input logic [2:0] el,
                             input logic [9:0] mr, input logic [2:0] er,
                             input int exp_ur, input bit hs);
    logic [31:0] so_bits;
    logic [31:0] sh1_bits;
    logic [31:0] sh2_bits;
    logic        b, s1, s2;
    so_bits  = '0;
    sh1_bits = '0;
    sh2_bits = '0;
    ur_cnt   = 0;
    ur_wide  = 0;
    acc_cnt  = 0;
    rdy_cnt  = 0;
    stab_err = 0;
    per_err  = 0;
    for (int i = 0; i < 32; i++) begin
      next_bit(b, s1, s2);
      so_bits[i]  = b;
      sh1_bits[i] = s1;
      sh2_bits[i] = s2;
    end
    check({tag, ".left"},  32'(so_bits[15:0]),  32'(word(ml, el)));
    check({tag, ".right"}, 32'(so_bits[31:16]), 32'(word(mr, er)));
    check({tag, ".sh1"},   sh1_bits, 32'h0000_8000);
    check({tag, ".sh2"},   sh2_bits, 32'h8000_0000);
    check({tag, ".underrun"}, 32'(ur_cnt), 32'(exp_ur));
    check({tag, ".ur_width"}, 32'(ur_wide), 32'd0);
    check({tag, ".stable"},   32'(stab_err), 32'd0);
    check({tag, ".period"},   32'(per_err), 32'd0);
    if (hs) begin
      check({tag, ".accepts"}, 32'(acc_cnt), 32'd1);
      check({tag, ".ready_cycles"}, 32'(rdy_cnt), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".dac_clk"},  32'(dac_clk), 32'd0);
    check({tag, ".dac_so"},   32'(dac_so), 32'd0);
    check({tag, ".dac_sh1"},  32'(dac_sh1), 32'd0);
    check({tag, ".dac_sh2"},  32'(dac_sh2), 32'd0);
    check({tag, ".underrun"}, 32'(underrun), 32'd0);
    check({tag, ".ready"},    32'(sample_ready), 32'd1);
  endtask

  initial begin
    logic r;
    logic b, s1, s2;

    // Reset state
    repeat (3) tick(r);
    check_reset_outputs("reset");

    // First frame after reset: nothing offered, so 0/0 repeats with underrun.
    release_reset();
    check_frame("f0_zero", 10'h000, 3'd1, 10'h000, 3'd1, 1, 1'b0);

    // L=0x0001 R=0x0000: left bits 000 1000000000 100
    send_pair(16'h0001, 16'h0000);
    check_frame("f1_one", 10'h001, 3'd1, 10'h000, 3'd1, 0, 1'b0);

    // Full-scale extremes
    send_pair(16'h7FFF, 16'h8000);
    check_frame("f2_full", 10'h1FF, 3'd7, 10'h200, 3'd7, 0, 1'b0);

    // Exponent boundary: 512 needs e=2, -512 still fits e=1
    send_pair(16'h0200, 16'hFE00);
    check_frame("f3_edge", 10'h100, 3'd2, 10'h200, 3'd1, 0, 1'b0);

    // 0x1234 -> m=0x123 e=5; 0x4321 -> m=0x10C e=7; then two starved frames
    send_pair(16'h1234, 16'h4321);
    check_frame("f4_pair", 10'h123, 3'd5, 10'h10C, 3'd7, 0, 1'b0);
    check_frame("f5_rep1", 10'h123, 3'd5, 10'h10C, 3'd7, 1, 1'b0);
    check_frame("f6_rep2", 10'h123, 3'd5, 10'h10C, 3'd7, 1, 1'b0);

    // Valid held high: 0x0100 -> m=0x100 e=1; 0x0300 -> m=0x180 e=2
    sample_l     = 16'h0100;
    sample_r     = 16'h0300;
    sample_valid = 1'b1;
    check_frame("f7_stream", 10'h100, 3'd1, 10'h180, 3'd2, 0, 1'b0);
    check_frame("f8_stream", 10'h100, 3'd1, 10'h180, 3'd2, 0, 1'b1);
    check_frame("f9_stream", 10'h100, 3'd1, 10'h180, 3'd2, 0, 1'b1);
    sample_valid = 1'b0;
    check_frame("f10_drain", 10'h100, 3'd1, 10'h180, 3'd2, 0, 1'b0);

    // Reset in the middle of the right word (bit 20)
    for (int i = 0; i <= 20; i++) next_bit(b, s1, s2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (4) tick(r);
    check_reset_outputs("midreset_hold");
    release_reset();
    check_frame("f11_post", 10'h000, 3'd1, 10'h000, 3'd1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ym3016_serial_tx.md
YM3016_SERIAL_TX -- requirements
Module: ym3016_serial_tx

Interface — parameters
REQ-001 SHALL have parameter HALF_PERIOD, default 3: clk cycles per dac_clk half-period; legal range 2..255.

Interface — ports
REQ-002 SHALL have port clk, input, 1: single system clock (clk_24m domain); all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port sample_l, input, 16: left sample, signed two's complement.
REQ-005 SHALL have port sample_r, input, 16: right sample, signed two's complement.
REQ-006 SHALL have port sample_valid, input, 1: sample pair offered.
REQ-007 SHALL have port sample_ready, output, 1: holding register empty.
REQ-008 SHALL have port dac_clk, output, 1: serial bit clock to the YM3016-format receiver.
REQ-009 SHALL have port dac_so, output, 1: serial data.
REQ-010 SHALL have port dac_sh1, output, 1: left-word latch strobe.
REQ-011 SHALL have port dac_sh2, output, 1: right-word latch strobe.
REQ-012 SHALL have port underrun, output, 1: one-cycle pulse.

Function
REQ-013 Divider: 0..HALF_PERIOD-1 counter; toggle dac_clk on wrap, so the dac_clk period is 2*HALF_PERIOD clk cycles with a 50% duty cycle.
REQ-014 Data and strobe changes: dac_so, dac_sh1 and dac_sh2 SHALL change only in the clk cycle in which dac_clk goes 0->1, so they are stable at every dac_clk falling edge.
REQ-015 Frame: 32 bits, bit index 0..31, wraps 31->0; bits 0-15 carry the left word, bits 16-31 carry the right word.
REQ-016 Word layout, in transmit order: 3 zero bits; 10-bit mantissa, LSB first; 3-bit exponent, LSB first.
REQ-017 Float encoding: for signed sample s, exponent e = smallest value in 1..7 such that s >>> (e-1) fits in signed 10 bits (-512..511).
REQ-018 Mantissa = (s >>> (e-1))[9:0], arithmetic shift, truncation toward -inf; e=0 SHALL never be emitted.
REQ-019 Strobes: dac_sh1 = 1 exactly during bit 15; dac_sh2 = 1 exactly during bit 31; both 0 otherwise.
REQ-020 Handshake: sample_ready = !hold_full; transfer occurs on a clk edge with sample_valid && sample_ready; the pair is captured into the holding register and hold_full is set.
REQ-021 Frame load: in the clk cycle driving bit 0, if hold_full, the held pair SHALL be encoded into the shift register and hold_full cleared in that same cycle.
REQ-022 Underrun: if hold_full is 0 in the bit-0 load cycle, the last transmitted pair SHALL be re-sent and underrun SHALL pulse for 1 clk cycle.
REQ-023 Simultaneous transfer and load (hold empty, valid high, bit-0 cycle): the pair SHALL enter the holding register; the current frame repeats the last pair and underrun pulses.
REQ-024 Latency: a pair accepted at least one clk cycle before a bit-0 cycle SHALL start transmitting at that bit 0.
REQ-025 The held pair SHALL never be overwritten, because sample_ready is low while hold_full.

Reset
REQ-026 While reset_n = 0, all outputs SHALL be 0 except sample_ready = 1.
REQ-027 While reset_n = 0: divider = 0, bit index = 31, hold_full = 0, last pair = 0/0.
REQ-028 After reset release, the first dac_clk rise SHALL occur HALF_PERIOD cycles later and carry bit 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no strobe SHALL be emitted for a partial word.

Verification
REQ-030 Bench SHALL cover: L=0x0001, R=0x0000 -> left bits 000 1000000000 100 (m=0x001, e=1); right m=0x000, e=1; sh1 high only at bit 15, sh2 high only at bit 31.
REQ-031 Bench SHALL cover: L=0x7FFF, R=0x8000 -> left m=0x1FF, e=7; right m=0x200, e=7.
REQ-032 Bench SHALL cover: L=0x0200, R=0xFE00 -> left m=0x100, e=2; right m=0x200, e=1.
REQ-033 Bench SHALL cover: no valid for 2 frames after pair 0x1234/0x4321 -> both frames repeat that pair, underrun pulses twice, each pulse 1 cycle wide.
REQ-034 Bench SHALL cover: valid held high continuously -> exactly one acceptance per frame; sample_ready low from each acceptance until the next bit-0 cycle.
REQ-035 Bench SHALL cover: reset_n pulsed low at bit 20 -> outputs 0 within the same cycle; first post-reset frame carries 0/0 and signals underrun.
